// File: rtl/bit_serializer.sv
// bit_serializer: parallel word in on valid/ready, one bit out per DIV clocks
// with a one-cycle ser_en strobe; supports gapless back-to-back words.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_d,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(DIV - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("bit_serializer: WIDTH must be >= 2");
  end
  if (DIV < 1) begin : g_bad_div
    $error("bit_serializer: DIV must be >= 1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  sr;
  logic [BW-1:0]     bit_cnt;
  logic [DW-1:0]     div_cnt;
  logic              last;
  logic              accept;

  // Last cycle of the current word: a new word may be taken in gaplessly.
  always_comb begin
    last     = (state == SHIFT) &&
               (bit_cnt == LAST_BIT) &&
               (div_cnt == LAST_DIV);
    in_ready = (state == IDLE) || last;
    accept   = in_valid && in_ready;
  end

  assign busy = (state == SHIFT);

  // Shift engine: load on accept, advance one bit every DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      ser_d   <= 1'b0;
      ser_en  <= 1'b0;
      done    <= 1'b0;
    end else begin
      ser_en <= 1'b0;
      done   <= 1'b0;
      if (accept) begin
        done    <= last;
        state   <= SHIFT;
        sr      <= in_data;
        bit_cnt <= '0;
        div_cnt <= '0;
        ser_en  <= 1'b1;
        if (MSB_FIRST != 0) ser_d <= in_data[WIDTH-1];
        else                ser_d <= in_data[0];
      end else if (state == SHIFT) begin
        if (div_cnt == LAST_DIV) begin
          div_cnt <= '0;
          if (bit_cnt != LAST_BIT) begin
            bit_cnt <= bit_cnt + 1'b1;
            ser_en  <= 1'b1;
            if (MSB_FIRST != 0) begin
              sr    <= {sr[WIDTH-2:0], 1'b0};
              ser_d <= sr[WIDTH-2];
            end else begin
              sr    <= {1'b0, sr[WIDTH-1:1]};
              ser_d <= sr[1];
            end
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench for bit_serializer in the default
// configuration (W8/D4/MSB) and in a W8/D1/LSB configuration.
module tb_bit_serializer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       ser_d;
  logic       ser_en;
  logic       busy;
  logic       done;

  logic       in_valid_b;
  logic       in_ready_b;
  logic [7:0] in_data_b;
  logic       ser_d_b;
  logic       ser_en_b;
  logic       busy_b;
  logic       done_b;
  logic       q_b;

  int vectors;
  int miscompares;

  logic sb[$];

  bit_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .ser_d    (ser_d),
    .ser_en   (ser_en),
    .busy     (busy),
    .done     (done)
  );

  bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(0)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid_b),
    .in_ready (in_ready_b),
    .in_data  (in_data_b),
    .ser_d    (ser_d_b),
    .ser_en   (ser_en_b),
    .busy     (busy_b),
    .done     (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream enabled register fed by the DIV=1 instance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        q_b <= 1'b0;
    else if (ser_en_b) q_b <= ser_d_b;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0;
    in_valid_b = 1'b0; in_data_b = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ser_en, ser_d, busy, done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outs got %b want 0000",
               {ser_en, ser_d, busy, done});
    end
    vectors++;
    if ({ser_en_b, ser_d_b, busy_b, done_b} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outs_b got %b want 0000",
               {ser_en_b, ser_d_b, busy_b, done_b});
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({in_ready, in_ready_b} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_ready got %b want 11", {in_ready, in_ready_b});
    end
    @(negedge clk);
  endtask

  task automatic test_idle();
    for (int c = 0; c < 50; c++) begin
      vectors++;
      if ({ser_en, busy, done, in_ready} !== 4'b0001) begin
        miscompares++;
        $display("FAIL idle c=%0d got %b want 0001", c,
                 {ser_en, busy, done, in_ready});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    logic [7:0] w;
    logic [3:0] exp;
    logic b;
    int n;
    w = 8'hA5;
    n = 0;
    in_valid = 1'b1; in_data = w;
    for (int i = 7; i >= 0; i--) sb.push_back(w[i]);
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    for (int c = 0; c <= 40; c++) begin
      exp[3] = (c % 4 == 0) && (c <= 28);
      exp[2] = (c >= 31);
      exp[1] = (c == 32);
      exp[0] = (c < 32);
      vectors++;
      if ({ser_en, in_ready, done, busy} !== exp) begin
        miscompares++;
        $display("FAIL single c=%0d en/rdy/done/busy got %b want %b",
                 c, {ser_en, in_ready, done, busy}, exp);
      end
      if (ser_en) begin
        n++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL single_extra c=%0d got strobe want none", c);
        end else begin
          b = sb.pop_front();
          if (ser_d !== b) begin
            miscompares++;
            $display("FAIL single_bit c=%0d got %b want %b", c, ser_d, b);
          end
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (n != 8 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL single_count got %0d strobes left %0d want 8 left 0",
               n, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0;
    logic [7:0] w1;
    logic [3:0] exp;
    logic b;
    int n;
    int nd;
    w0 = 8'hA5;
    w1 = 8'h3C;
    n = 0;
    nd = 0;
    in_valid = 1'b1; in_data = w0;
    for (int i = 7; i >= 0; i--) sb.push_back(w0[i]);
    @(negedge clk);
    in_data = w1;
    for (int i = 7; i >= 0; i--) sb.push_back(w1[i]);
    for (int c = 0; c <= 72; c++) begin
      exp[3] = (c % 4 == 0) && (c <= 60);
      exp[2] = (c == 31) || (c >= 63);
      exp[1] = (c == 32) || (c == 64);
      exp[0] = (c < 64);
      vectors++;
      if ({ser_en, in_ready, done, busy} !== exp) begin
        miscompares++;
        $display("FAIL b2b c=%0d en/rdy/done/busy got %b want %b",
                 c, {ser_en, in_ready, done, busy}, exp);
      end
      if (done) nd++;
      if (ser_en) begin
        n++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_extra c=%0d got strobe want none", c);
        end else begin
          b = sb.pop_front();
          if (ser_d !== b) begin
            miscompares++;
            $display("FAIL b2b_bit c=%0d got %b want %b", c, ser_d, b);
          end
        end
      end
      if (c == 32) begin
        in_valid = 1'b0; in_data = '0;
      end
      @(negedge clk);
    end
    vectors++;
    if (n != 16 || nd != 2 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_count got %0d strobes %0d done want 16 and 2",
               n, nd);
    end
    sb.delete();
  endtask

  task automatic test_div1();
    logic [7:0] w;
    logic [4:0] exp;
    int nq;
    w = 8'h01;
    nq = 0;
    in_valid_b = 1'b1; in_data_b = w;
    for (int i = 0; i < 8; i++) sb.push_back(w[i]);
    @(negedge clk);
    in_valid_b = 1'b0; in_data_b = '0;
    for (int c = 0; c <= 12; c++) begin
      exp[4] = (c <= 7);
      exp[3] = (c >= 7);
      exp[2] = (c == 8);
      exp[1] = (c < 8);
      exp[0] = (c == 1);
      vectors++;
      if ({ser_en_b, in_ready_b, done_b, busy_b, q_b} !== exp) begin
        miscompares++;
        $display("FAIL div1 c=%0d en/rdy/done/busy/q got %b want %b",
                 c, {ser_en_b, in_ready_b, done_b, busy_b, q_b}, exp);
      end
      if (q_b) nq++;
      if (ser_en_b && sb.size() != 0) begin
        logic b;
        b = sb.pop_front();
        vectors++;
        if (ser_d_b !== b) begin
          miscompares++;
          $display("FAIL div1_bit c=%0d got %b want %b", c, ser_d_b, b);
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (nq != 1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL div1_q got %0d q-cycles left %0d want 1 left 0",
               nq, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_ignore_busy();
    logic [7:0] w;
    logic [3:0] exp;
    logic b;
    int n;
    w = 8'h5A;
    n = 0;
    in_valid = 1'b1; in_data = w;
    for (int i = 7; i >= 0; i--) sb.push_back(w[i]);
    @(negedge clk);
    for (int c = 0; c <= 40; c++) begin
      exp[3] = (c % 4 == 0) && (c <= 28);
      exp[2] = (c >= 31);
      exp[1] = (c == 32);
      exp[0] = (c < 32);
      vectors++;
      if ({ser_en, in_ready, done, busy} !== exp) begin
        miscompares++;
        $display("FAIL ignore c=%0d en/rdy/done/busy got %b want %b",
                 c, {ser_en, in_ready, done, busy}, exp);
      end
      if (ser_en) begin
        n++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL ignore_extra c=%0d got strobe want none", c);
        end else begin
          b = sb.pop_front();
          if (ser_d !== b) begin
            miscompares++;
            $display("FAIL ignore_bit c=%0d got %b want %b", c, ser_d, b);
          end
        end
      end
      in_data  = 8'hFF;
      in_valid = (c < 28) ? c[0] : 1'b0;
      @(negedge clk);
    end
    in_data = '0;
    vectors++;
    if (n != 8 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL ignore_count got %0d strobes want 8", n);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    logic [3:0] exp;
    logic b;
    int n;
    w = 8'hA5;
    in_valid = 1'b1; in_data = w;
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    repeat (13) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_busy_pre got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ser_en, ser_d, busy, done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL rmid_async got %b want 0000",
               {ser_en, ser_d, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      vectors++;
      if ({done, busy, in_ready} !== 3'b001) begin
        miscompares++;
        $display("FAIL rmid_after c=%0d done/busy/rdy got %b want 001",
                 c, {done, busy, in_ready});
      end
      @(negedge clk);
    end
    w = 8'hC3;
    n = 0;
    in_valid = 1'b1; in_data = w;
    for (int i = 7; i >= 0; i--) sb.push_back(w[i]);
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    for (int c = 0; c <= 36; c++) begin
      exp[3] = (c % 4 == 0) && (c <= 28);
      exp[2] = (c >= 31);
      exp[1] = (c == 32);
      exp[0] = (c < 32);
      vectors++;
      if ({ser_en, in_ready, done, busy} !== exp) begin
        miscompares++;
        $display("FAIL rmid_word c=%0d en/rdy/done/busy got %b want %b",
                 c, {ser_en, in_ready, done, busy}, exp);
      end
      if (ser_en) begin
        n++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rmid_extra c=%0d got strobe want none", c);
        end else begin
          b = sb.pop_front();
          if (ser_d !== b) begin
            miscompares++;
            $display("FAIL rmid_bit c=%0d got %b want %b", c, ser_d, b);
          end
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (n != 8 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL rmid_count got %0d strobes want 8", n);
    end
    sb.delete();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_div1();
    test_ignore_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
